jk_cmd_sequencer: RTL and testbench
===================================

// Module: jk_cmd_sequencer
// PURPOSE
// Upstream driver for the JK flip-flop stage. Accepts JK commands {jk, hold} over a
// valid/ready handshake and buffers them in a small FIFO. Drives each command's jk code
// onto the flip-flop's 2-bit jk input for hold+1 consecutive clocks, then moves to the next.
// Optionally tracks the expected q and flags any divergence from the flip-flop's q output.
// PARAMETERS
// HOLD_W  4  width of per-command hold count; a command lasts 1..2**HOLD_W cycles
// DEPTH   4  FIFO entries; power of 2, >=2
// PORTS
// clk       in   1       rising-edge clock, shared with the JK flip-flop
// rst       in   1       synchronous, active-high reset
// in_valid  in   1       command present
// in_ready  out  1       FIFO can accept (count != DEPTH)
// in_jk     in   2       jk code: 00 hold, 01 reset, 10 set, 11 toggle
// in_hold   in   HOLD_W  extra cycles to hold code (0 = 1 cycle)
// jk        out  2       registered; drives flip-flop jk
// busy      out  1       state==APPLY or FIFO non-empty
// done      out  1       1-cycle pulse: last command finished, FIFO empty
// q_fb      in   1       flip-flop q (JKSEQ_CHECK_EN only)
// exp_q     out  1       modelled q (JKSEQ_CHECK_EN only)
// mismatch  out  1       sticky q_fb!=exp_q (JKSEQ_CHECK_EN only)
// BEHAVIOUR
// - Reset (sampled at posedge): jk=00, FIFO emptied (count=0, pointers=0), state=IDLE,
//   cnt=0, done=0, exp_q=0, mismatch=0. in_ready=1 on the first cycle after reset.
// - Reset mid-command: abandons the command and flushes the FIFO; jk=00 after that edge.
// - Push: in_valid & in_ready at posedge writes {in_jk,in_hold}. Push while full is ignored.
// - in_ready depends only on registered count (no fall-through): pop+push in the same cycle
//   is legal, and count is unchanged. A full FIFO does not accept even if a pop occurs.
// - FSM IDLE: if FIFO non-empty -> pop; jk<=entry.jk, cnt<=entry.hold, go APPLY.
//   Otherwise jk stays 00.
// - FSM APPLY: if cnt!=0 -> cnt<=cnt-1, jk held.
//   If cnt==0 and FIFO non-empty -> pop the next entry back-to-back (no bubble cycle).
//   If cnt==0 and FIFO empty -> jk<=00, go IDLE, done<=1 for one cycle.
// - Latency: a command pushed at edge T into an empty FIFO in IDLE appears on jk after
//   edge T+1.
// - Each command holds jk for exactly hold+1 clocks.
// - Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.
// - busy is combinational from registers. jk never carries X after reset.
// CONFIGURATION
// - JKSEQ_CHECK_EN defined: q_fb/exp_q/mismatch ports exist.
//   - exp_q updates at every posedge from the current jk value, with the same case table as
//     the flip-flop (00 keep, 01 ->0, 10 ->1, 11 invert), so exp_q and the flip-flop's q
//     change on the same edge.
//   - mismatch<=1 at any posedge (rst low) where q_fb!=exp_q. It stays set until rst.
//   - exp_q resets to 0, matching the flip-flop's power-up q=0.
// - JKSEQ_CHECK_EN undefined: those three ports and their logic are absent; the rest of
//   the block is unchanged.
// TESTING
// - Reset, then push {10,h=0},{01,h=0},{11,h=1},{00,h=0} in 4 cycles -> after edge T+1,
//   jk = 10,01,11,11,00; done pulses once 1 cycle after the 00 command ends; busy then 0.
// - Push 5 commands, each h=3, with in_valid held high -> in_ready drops when count==4;
//   no entry is lost or duplicated; 20 jk cycles total.
// - Push {11,h=15} -> jk=11 for exactly 16 cycles; a following {10,h=0} queued during
//   that time follows with no 00 bubble.
// - Assert rst for 1 cycle while in APPLY with 3 entries queued -> jk=00, busy=0 after
//   that edge; a push in the next cycle starts fresh.
// - JKSEQ_CHECK_EN: connect the JK flip-flop (q->q_fb) and send 10,11,11,01,00
//   -> exp_q tracks 1,0,1,0,0 and mismatch stays 0.
// - JKSEQ_CHECK_EN: force q_fb=1 while exp_q=0 for one cycle -> mismatch=1 and stays
//   set until rst.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// Command sequencer feeding a JK flip-flop: buffers {jk, hold} commands and plays each for hold+1 clocks.
// Optional q tracking and mismatch flag when JKSEQ_CHECK_EN is defined.
module jk_cmd_sequencer #(
  parameter int HOLD_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_jk,
  input  logic [HOLD_W-1:0] in_hold,
  output logic [1:0]        jk,
  output logic              busy,
  output logic              done
`ifdef JKSEQ_CHECK_EN
  ,
  input  logic              q_fb,
  output logic              exp_q,
  output logic              mismatch
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 + HOLD_W;
  localparam logic [0:0]        IDLE     = 1'b0;
  localparam logic [0:0]        APPLY    = 1'b1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [EW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [0:0]        state_r;
  logic [HOLD_W-1:0] cnt_r;
  logic [1:0]        jk_r;
  logic              done_r;

  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic [EW-1:0]     head_s;
  logic [0:0]        state_d_s;
  logic [HOLD_W-1:0] cnt_d_s;
  logic [1:0]        jk_d_s;
  logic              done_d_s;
  logic [CW-1:0]     count_d_s;

  // in_ready looks only at the registered count, so a full FIFO refuses even on a pop cycle
  assign in_ready = (count_r != FULL_CNT);
  assign empty_s  = (count_r == {CW{1'b0}});
  assign push_s   = in_valid & in_ready;
  assign head_s   = mem_r[rd_ptr_r];
  assign busy     = (state_r == APPLY) | ~empty_s;
  assign jk       = jk_r;
  assign done     = done_r;

  // Sequencer next-state: pop when idle, or back-to-back when the current hold runs out
  always_comb begin
    pop_s     = 1'b0;
    state_d_s = state_r;
    cnt_d_s   = cnt_r;
    jk_d_s    = jk_r;
    done_d_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s     = 1'b1;
          jk_d_s    = head_s[EW-1 -: 2];
          cnt_d_s   = head_s[HOLD_W-1:0];
          state_d_s = APPLY;
        end else begin
          jk_d_s    = 2'b00;
        end
      end
      APPLY: begin
        if (cnt_r != {HOLD_W{1'b0}}) begin
          cnt_d_s   = cnt_r - HOLD_ONE;
        end else if (!empty_s) begin
          pop_s     = 1'b1;
          jk_d_s    = head_s[EW-1 -: 2];
          cnt_d_s   = head_s[HOLD_W-1:0];
        end else begin
          jk_d_s    = 2'b00;
          state_d_s = IDLE;
          done_d_s  = 1'b1;
        end
      end
      default: begin
        jk_d_s    = 2'b00;
        cnt_d_s   = {HOLD_W{1'b0}};
        state_d_s = IDLE;
      end
    endcase
  end

  // FIFO occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_d_s = count_r + CNT_ONE;
      2'b01:   count_d_s = count_r - CNT_ONE;
      default: count_d_s = count_r;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      state_r  <= IDLE;
      cnt_r    <= {HOLD_W{1'b0}};
      jk_r     <= 2'b00;
      done_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_d_s;
      state_r <= state_d_s;
      cnt_r   <= cnt_d_s;
      jk_r    <= jk_d_s;
      done_r  <= done_d_s;
    end
  end

  // FIFO storage; contents are only read once count says they were written
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_jk, in_hold};
    end
  end

`ifdef JKSEQ_CHECK_EN
  logic exp_q_r;
  logic mismatch_r;

  function automatic logic jk_next(input logic q, input logic [1:0] code);
    case (code)
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  // Shadow flip-flop tracking the driven jk; divergence is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q_r    <= 1'b0;
      mismatch_r <= 1'b0;
    end else begin
      exp_q_r    <= jk_next(exp_q_r, jk_r);
      mismatch_r <= mismatch_r | (q_fb != exp_q_r);
    end
  end

  assign exp_q    = exp_q_r;
  assign mismatch = mismatch_r;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed self-checking bench for jk_cmd_sequencer; define JKSEQ_CHECK_EN to add the q-tracking scenarios.
module tb_jk_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_jk = 2'b00;
  logic [3:0] in_hold = 4'd0;
  logic [1:0] jk;
  logic       busy;
  logic       done;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

`ifdef JKSEQ_CHECK_EN
  logic q_fb;
  logic exp_q;
  logic mismatch;
  logic ff_q;
  logic force_q = 1'b0;

  // Reference JK flip-flop driven by the sequencer
  always_ff @(posedge clk) begin
    if (rst) ff_q <= 1'b0;
    else case (jk)
      2'b01:   ff_q <= 1'b0;
      2'b10:   ff_q <= 1'b1;
      2'b11:   ff_q <= ~ff_q;
      default: ff_q <= ff_q;
    endcase
  end
  assign q_fb = force_q ? 1'b1 : ff_q;

  jk_cmd_sequencer #(.HOLD_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_jk(in_jk), .in_hold(in_hold), .jk(jk), .busy(busy), .done(done),
    .q_fb(q_fb), .exp_q(exp_q), .mismatch(mismatch));
`else
  jk_cmd_sequencer #(.HOLD_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_jk(in_jk), .in_hold(in_hold), .jk(jk), .busy(busy), .done(done));
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    checks++; if (jk !== 2'b00)  begin errors++; $display("FAIL reset_jk: got %b want 00", jk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef JKSEQ_CHECK_EN
    checks++; if (exp_q !== 1'b0)    begin errors++; $display("FAIL reset_exp_q: got %b want 0", exp_q); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %b want 0", mismatch); end
`endif
  endtask

  task automatic test_basic();
    logic [1:0] cj [4];
    logic [3:0] ch [4];
    logic [1:0] ej [8];
    logic       ed [8];
    cj = '{2'b10, 2'b01, 2'b11, 2'b00};
    ch = '{4'd0, 4'd0, 4'd1, 4'd0};
    ej = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_jk = cj[i]; in_hold = ch[i];
      end else begin
        in_valid = 1'b0;
      end
      step();
      checks++; if (jk !== ej[i])   begin errors++; $display("FAIL basic_jk[%0d]: got %b want %b", i, jk, ej[i]); end
      checks++; if (done !== ed[i]) begin errors++; $display("FAIL basic_done[%0d]: got %b want %b", i, done, ed[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_full();
    logic [1:0] cj [5];
    logic [1:0] ej;
    int         sent = 0;
    logic       rdy;
    cj = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    for (int i = 0; i < 23; i++) begin
      in_valid = (sent < 5);
      in_jk    = (sent < 5) ? cj[sent] : 2'b00;
      in_hold  = 4'd3;
      rdy      = in_ready;
      step();
      if (in_valid && rdy) sent++;
      ej = (i >= 1 && i <= 20) ? cj[(i - 1) / 4] : 2'b00;
      checks++; if (jk !== ej) begin errors++; $display("FAIL full_jk[%0d]: got %b want %b", i, jk, ej); end
      checks++; if (done !== (i == 21)) begin errors++; $display("FAIL full_done[%0d]: got %b want %b", i, done, (i == 21)); end
      if (i == 3) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_e3: got %b want 1", in_ready); end
      end
      if (i == 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_e4: got %b want 0", in_ready); end
      end
    end
    in_valid = 1'b0;
    checks++; if (sent !== 5) begin errors++; $display("FAIL full_sent: got %0d want 5", sent); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ej;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 2);
      in_jk    = (i == 0) ? 2'b11 : 2'b10;
      in_hold  = (i == 0) ? 4'd15 : 4'd0;
      step();
      ej = (i >= 1 && i <= 16) ? 2'b11 : ((i == 17) ? 2'b10 : 2'b00);
      checks++; if (jk !== ej) begin errors++; $display("FAIL b2b_jk[%0d]: got %b want %b", i, jk, ej); end
      checks++; if (done !== (i == 18)) begin errors++; $display("FAIL b2b_done[%0d]: got %b want %b", i, done, (i == 18)); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_jk = 2'b11; in_hold = 4'd3;
      step();
    end
    in_valid = 1'b0;
    checks++; if (jk !== 2'b11)  begin errors++; $display("FAIL mid_pre_jk: got %b want 11", jk); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %b want 1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (jk !== 2'b00)      begin errors++; $display("FAIL mid_rst_jk: got %b want 00", jk); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
    in_valid = 1'b1; in_jk = 2'b01; in_hold = 4'd0;
    step();
    in_valid = 1'b0;
    checks++; if (jk !== 2'b00) begin errors++; $display("FAIL mid_fresh_lat: got %b want 00", jk); end
    step();
    checks++; if (jk !== 2'b01) begin errors++; $display("FAIL mid_fresh_jk: got %b want 01", jk); end
    step();
    checks++; if (jk !== 2'b00)  begin errors++; $display("FAIL mid_fresh_end: got %b want 00", jk); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_fresh_done: got %b want 1", done); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b want 0", busy); end
    checks++; if (jk !== 2'b00)  begin errors++; $display("FAIL mid_no_stale_jk: got %b want 00", jk); end
  endtask

`ifdef JKSEQ_CHECK_EN
  task automatic test_track();
    logic [1:0] cj [5];
    logic       eq [8];
    cj = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
    eq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 5);
      in_jk    = (i < 5) ? cj[i] : 2'b00;
      in_hold  = 4'd0;
      step();
      checks++; if (exp_q !== eq[i])    begin errors++; $display("FAIL track_exp_q[%0d]: got %b want %b", i, exp_q, eq[i]); end
      checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL track_mismatch[%0d]: got %b want 0", i, mismatch); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mismatch();
    checks++; if (exp_q !== 1'b0) begin errors++; $display("FAIL mm_pre_exp_q: got %b want 0", exp_q); end
    force_q = 1'b1;
    step();
    force_q = 1'b0;
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_set: got %b want 1", mismatch); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_sticky[%0d]: got %b want 1", i, mismatch); end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mm_clear: got %b want 0", mismatch); end
    step();
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mm_after: got %b want 0", mismatch); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef JKSEQ_CHECK_EN
    test_track();
    test_mismatch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
